cop_wb_queue: RTL

Writeback queue directly downstream of the photon ISE co-processor interface. Captures each accepted co-processor result (`cop_wr`/`cop_rd` plus the destination index from `cop_insn[11:7]`) into a small FIFO and presents it to the core register-file writeback port through a valid/ready handshake. It drives `cop_rdywr` back to the interface, so the co-processor stalls via `cop_ready` only when the queue is full. A lookup port reports pending writes so the core scoreboard can block dependent reads.

---
 rtl/cop_wb_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/cop_wb_queue.sv
// Writeback queue between the photon ISE co-processor interface and the core
// register-file writeback port, with a pending-write lookup for the scoreboard.
module cop_wb_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic        cop_clk,
  input  logic        cop_rst,
  input  logic        cop_wr,
  input  logic [31:0] cop_insn,
  input  logic [31:0] cop_rd,
  output logic        cop_rdywr,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic [4:0]  chk_addr,
  output logic        chk_hit,
  output logic        ovf_err
);

  logic [4:0]  addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          cop_wr_q;
  logic          ovf_q;

  logic        full, empty, acc, push, pop, ovf_set;
  logic [4:0]  dst;

  assign dst       = cop_insn[11:7];
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign cop_rdywr = ~full;
  assign acc       = cop_wr & cop_rdywr;
  // Writes to x0 retire the instruction but never occupy a slot.
  assign push      = acc & (dst != 5'd0);
  assign pop       = wb_valid & wb_ready;
  // A strobe held across a stall is legal; only a fresh strobe while full is an error.
  assign ovf_set   = cop_wr & full & ~cop_wr_q;

  assign wb_valid = ~empty;
  assign wb_addr  = empty ? 5'd0 : addr_q[rp_q];
  assign wb_data  = empty ? 32'd0 : data_q[rp_q];
  assign ovf_err  = ovf_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    logic [AW-1:0] off;
    chk_hit = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rp_q;
      if (({1'b0, off} < cnt_q) && (addr_q[i] == chk_addr) && (chk_addr != 5'd0)) begin
        chk_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge cop_clk or posedge cop_rst) begin
    if (cop_rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      cop_wr_q <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      cop_wr_q <= cop_wr;
      if (ovf_set) ovf_q <= 1'b1;
      if (push && !flush) begin
        addr_q[wp_q] <= dst;
        data_q[wp_q] <= cop_rd;
      end
    end
  end

endmodule
